// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the fetch PC (pc_f), selects the next fetch address from the
// sequential / jump / register-jump / interrupt / exception / branch sources,
// and loads the IF/ID register (instruct, pc, irqout) with either the fetched
// word, a held value (stall) or a bubble (redirect / flush).
// External interrupts are edge-detected into a pending flag and delivered as
// a single irqout pulse on the first eligible user-mode (pc_f[31]=0) fetch.
//
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  synchronous reset, active low
//   stall        in   1  hold fetch PC and IF/ID
//   flush        in   1  force bubble into IF/ID
//   pc_src       in   3  ID redirect select (2 jump, 3 jr, 4 irq, 5 exc)
//   jt           in  26  ID jump index
//   jr_target    in  32  ID register-jump target
//   branch_taken in   1  EX branch resolved taken
//   conba        in  32  EX branch target
//   irq_req      in   1  external interrupt request, level
//   imem_addr    out 32  instruction memory address (= pc_f)
//   imem_rdata   in  32  instruction word for imem_addr
//   pc_f         out 32  current fetch PC
//   instruct     out 32  IF/ID instruction
//   pc           out 32  IF/ID PC
//   irqout       out  1  IF/ID interrupt-take flag
// ----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
   parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [2:0]  pc_src,
   input  logic [25:0] jt,
   input  logic [31:0] jr_target,
   input  logic        branch_taken,
   input  logic [31:0] conba,
   input  logic        irq_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instruct,
   output logic [31:0] pc,
   output logic        irqout
);

   logic [31:0] r_pc_f;
   logic [31:0] r_instruct;
   logic [31:0] r_pc;
   logic        r_irqout;
   logic        r_irq_pend;
   logic        r_irq_req_d;
   logic        r_irq_sent;   // irqout already delivered for this pending episode

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jump_target;
   logic [31:0] w_next_pc;
   logic        w_redirect;
   logic        w_irq_edge;
   logic        w_irq_clear;
   logic        w_irq_take;
   logic        w_capture;

   // Supervisor bit is sticky across sequential fetch; low 31 bits wrap.
   assign w_pc_plus4    = {r_pc_f[31], r_pc_f[30:0] + 31'd4};
   assign w_jump_target = {r_pc[31:28], jt, 2'b00};

   // Branch resolved in EX outranks everything, including a stall, because
   // the stalled instruction is on the wrong path anyway.
   assign w_redirect = branch_taken |
                       (~stall & (pc_src >= 3'd2) & (pc_src <= 3'd5));
   assign w_capture  = ~w_redirect & ~flush & ~stall;

   assign w_irq_edge  = irq_req & ~r_irq_req_d;
   assign w_irq_clear = (pc_src == 3'd4) & ~stall;
   // Masked in supervisor space; only one pulse per pending episode.
   assign w_irq_take  = r_irq_pend & ~r_pc_f[31] & ~r_irq_sent;

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (branch_taken) begin
         w_next_pc = conba;
      end else if (stall) begin
         w_next_pc = r_pc_f;
      end else begin
         case (pc_src)
            3'd5:    w_next_pc = EXC_VEC;
            3'd4:    w_next_pc = IRQ_VEC;
            3'd3:    w_next_pc = jr_target;
            3'd2:    w_next_pc = w_jump_target;
            default: w_next_pc = w_pc_plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc_f      <= RESET_PC;
         r_instruct  <= 32'd0;
         r_pc        <= 32'd0;
         r_irqout    <= 1'b0;
         r_irq_pend  <= 1'b0;
         r_irq_req_d <= 1'b0;
         r_irq_sent  <= 1'b0;
      end else begin
         r_pc_f      <= w_next_pc;
         r_irq_req_d <= irq_req;

         if (w_redirect || flush) begin
            r_instruct <= 32'd0;
            r_pc       <= 32'd0;
            r_irqout   <= 1'b0;
         end else if (!stall) begin
            r_instruct <= imem_rdata;
            r_pc       <= r_pc_f;
            r_irqout   <= w_irq_take;
         end

         // A new request edge wins over a same-cycle acknowledge.
         if (w_irq_edge) begin
            r_irq_pend <= 1'b1;
         end else if (w_irq_clear) begin
            r_irq_pend <= 1'b0;
         end

         // Acknowledge (or a fresh edge arriving with it) starts a new episode.
         if (w_irq_clear) begin
            r_irq_sent <= 1'b0;
         end else if (w_capture && w_irq_take) begin
            r_irq_sent <= 1'b1;
         end
      end
   end

   assign imem_addr = r_pc_f;
   assign pc_f      = r_pc_f;
   assign instruct  = r_instruct;
   assign pc        = r_pc;
   assign irqout    = r_irqout;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// Instruction memory is modelled as imem_rdata = ~imem_addr, so every
// expected instruction word is the bitwise inverse of its fetch address.
// ----------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [2:0]  pc_src;
   logic [25:0] jt;
   logic [31:0] jr_target;
   logic        branch_taken;
   logic [31:0] conba;
   logic        irq_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_f;
   logic [31:0] instruct;
   logic [31:0] pc;
   logic        irqout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   if_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .pc_src       (pc_src),
      .jt           (jt),
      .jr_target    (jr_target),
      .branch_taken (branch_taken),
      .conba        (conba),
      .irq_req      (irq_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .pc_f         (pc_f),
      .instruct     (instruct),
      .pc           (pc),
      .irqout       (irqout)
   );

   assign imem_rdata = ~imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample 1 ns after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall        = 1'b0;
      flush        = 1'b0;
      pc_src       = 3'd0;
      jt           = 26'd0;
      jr_target    = 32'd0;
      branch_taken = 1'b0;
      conba        = 32'd0;
   endtask

   task automatic jump_reg(input logic [31:0] target);
      idle();
      pc_src    = 3'd3;
      jr_target = target;
      step();
      idle();
   endtask

   task automatic test_reset();
      idle();
      irq_req = 1'b0;
      reset   = 1'b0;
      step();
      step();
      total_cnt++; if (pc_f !== 32'h8000_0000) $display("FAIL reset_pcf got %h exp %h", pc_f, 32'h8000_0000); else pass_cnt++;
      total_cnt++; if (imem_addr !== 32'h8000_0000) $display("FAIL reset_imem_addr got %h exp %h", imem_addr, 32'h8000_0000); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL reset_instruct got %h exp %h", instruct, 32'h0); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
      total_cnt++; if (irqout !== 1'b0) $display("FAIL reset_irqout got %b exp 0", irqout); else pass_cnt++;
      $display("txn reset: pc_f=%h instruct=%h pc=%h irqout=%b", pc_f, instruct, pc, irqout);
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pcf [4];
      exp_pcf[0] = 32'h8000_0000;
      exp_pcf[1] = 32'h8000_0004;
      exp_pcf[2] = 32'h8000_0008;
      exp_pcf[3] = 32'h8000_000C;
      reset = 1'b1;
      idle();
      total_cnt++; if (pc_f !== exp_pcf[0]) $display("FAIL seq_pcf0 got %h exp %h", pc_f, exp_pcf[0]); else pass_cnt++;
      for (int i = 1; i < 4; i++) begin
         step();
         total_cnt++; if (pc_f !== exp_pcf[i]) $display("FAIL seq_pcf%0d got %h exp %h", i, pc_f, exp_pcf[i]); else pass_cnt++;
         total_cnt++; if (pc !== exp_pcf[i-1]) $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pcf[i-1]); else pass_cnt++;
         total_cnt++; if (instruct !== ~exp_pcf[i-1]) $display("FAIL seq_instr%0d got %h exp %h", i, instruct, ~exp_pcf[i-1]); else pass_cnt++;
         $display("txn seq %0d: pc_f=%h pc=%h instruct=%h", i, pc_f, pc, instruct);
      end
   endtask

   task automatic test_jump();
      jump_reg(32'h0000_000C);
      total_cnt++; if (pc_f !== 32'h0000_000C) $display("FAIL jr_pcf got %h exp %h", pc_f, 32'h0000_000C); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL jr_bubble got %h exp %h", instruct, 32'h0); else pass_cnt++;
      step();
      total_cnt++; if (pc_f !== 32'h0000_0010) $display("FAIL jmp_pre_pcf got %h exp %h", pc_f, 32'h0000_0010); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0000_000C) $display("FAIL jmp_pre_pc got %h exp %h", pc, 32'h0000_000C); else pass_cnt++;
      total_cnt++; if (instruct !== 32'hFFFF_FFF3) $display("FAIL jmp_pre_instr got %h exp %h", instruct, 32'hFFFF_FFF3); else pass_cnt++;
      pc_src = 3'd2;
      jt     = 26'h40;
      step();
      idle();
      total_cnt++; if (pc_f !== 32'h0000_0100) $display("FAIL jmp_pcf got %h exp %h", pc_f, 32'h0000_0100); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL jmp_bubble_instr got %h exp %h", instruct, 32'h0); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0) $display("FAIL jmp_bubble_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
      step();
      total_cnt++; if (pc !== 32'h0000_0100) $display("FAIL jmp_target_pc got %h exp %h", pc, 32'h0000_0100); else pass_cnt++;
      total_cnt++; if (instruct !== 32'hFFFF_FEFF) $display("FAIL jmp_target_instr got %h exp %h", instruct, 32'hFFFF_FEFF); else pass_cnt++;
      $display("txn jump: pc_f=%h pc=%h instruct=%h", pc_f, pc, instruct);
   endtask

   task automatic test_stall();
      jump_reg(32'h0000_001C);
      step();
      total_cnt++; if (pc_f !== 32'h0000_0020) $display("FAIL stall_pre_pcf got %h exp %h", pc_f, 32'h0000_0020); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         stall = 1'b1;
         step();
         total_cnt++; if (pc_f !== 32'h0000_0020) $display("FAIL stall_pcf%0d got %h exp %h", i, pc_f, 32'h0000_0020); else pass_cnt++;
         total_cnt++; if (pc !== 32'h0000_001C) $display("FAIL stall_pc%0d got %h exp %h", i, pc, 32'h0000_001C); else pass_cnt++;
         total_cnt++; if (instruct !== 32'hFFFF_FFE3) $display("FAIL stall_instr%0d got %h exp %h", i, instruct, 32'hFFFF_FFE3); else pass_cnt++;
         $display("txn stall %0d: pc_f=%h pc=%h instruct=%h", i, pc_f, pc, instruct);
      end
      idle();
      step();
      total_cnt++; if (pc_f !== 32'h0000_0024) $display("FAIL stall_resume_pcf got %h exp %h", pc_f, 32'h0000_0024); else pass_cnt++;
      total_cnt++; if (instruct !== 32'hFFFF_FFDF) $display("FAIL stall_resume_instr got %h exp %h", instruct, 32'hFFFF_FFDF); else pass_cnt++;
   endtask

   task automatic test_branch_priority();
      branch_taken = 1'b1;
      conba        = 32'h0000_0200;
      stall        = 1'b1;
      pc_src       = 3'd3;
      jr_target    = 32'h0000_1234;
      step();
      idle();
      total_cnt++; if (pc_f !== 32'h0000_0200) $display("FAIL br_pcf got %h exp %h", pc_f, 32'h0000_0200); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL br_bubble got %h exp %h", instruct, 32'h0); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0) $display("FAIL br_bubble_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
      step();
      total_cnt++; if (pc_f !== 32'h0000_0204) $display("FAIL br_next_pcf got %h exp %h", pc_f, 32'h0000_0204); else pass_cnt++;
      total_cnt++; if (instruct !== 32'hFFFF_FDFF) $display("FAIL br_target_instr got %h exp %h", instruct, 32'hFFFF_FDFF); else pass_cnt++;
      $display("txn branch: pc_f=%h pc=%h instruct=%h", pc_f, pc, instruct);
   endtask

   task automatic test_exc_flush();
      pc_src = 3'd5;
      step();
      idle();
      total_cnt++; if (pc_f !== 32'h8000_0008) $display("FAIL exc_pcf got %h exp %h", pc_f, 32'h8000_0008); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL exc_bubble got %h exp %h", instruct, 32'h0); else pass_cnt++;
      step();
      total_cnt++; if (pc !== 32'h8000_0008) $display("FAIL exc_pc got %h exp %h", pc, 32'h8000_0008); else pass_cnt++;
      flush = 1'b1;
      stall = 1'b1;
      step();
      total_cnt++; if (pc_f !== 32'h8000_000C) $display("FAIL flush_stall_pcf got %h exp %h", pc_f, 32'h8000_000C); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL flush_stall_instr got %h exp %h", instruct, 32'h0); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0) $display("FAIL flush_stall_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
      stall = 1'b0;
      step();
      idle();
      total_cnt++; if (pc_f !== 32'h8000_0010) $display("FAIL flush_pcf got %h exp %h", pc_f, 32'h8000_0010); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL flush_instr got %h exp %h", instruct, 32'h0); else pass_cnt++;
      $display("txn exc/flush: pc_f=%h pc=%h instruct=%h", pc_f, pc, instruct);
   endtask

   task automatic test_wrap();
      jump_reg(32'hFFFF_FFFC);
      step();
      total_cnt++; if (pc_f !== 32'h8000_0000) $display("FAIL wrap_sup_pcf got %h exp %h", pc_f, 32'h8000_0000); else pass_cnt++;
      jump_reg(32'h7FFF_FFFC);
      step();
      total_cnt++; if (pc_f !== 32'h0000_0000) $display("FAIL wrap_usr_pcf got %h exp %h", pc_f, 32'h0000_0000); else pass_cnt++;
      jump_reg(32'h0000_0003);
      total_cnt++; if (pc_f !== 32'h0000_0003) $display("FAIL jr_unaligned_pcf got %h exp %h", pc_f, 32'h0000_0003); else pass_cnt++;
      $display("txn wrap: pc_f=%h", pc_f);
   endtask

   task automatic test_irq();
      logic [31:0] exp_pc [3];
      logic        exp_irq [3];
      exp_pc[0] = 32'h0000_0040; exp_irq[0] = 1'b0;
      exp_pc[1] = 32'h0000_0044; exp_irq[1] = 1'b1;
      exp_pc[2] = 32'h0000_0048; exp_irq[2] = 1'b0;
      jump_reg(32'h0000_003C);
      step();
      total_cnt++; if (pc_f !== 32'h0000_0040) $display("FAIL irq_pre_pcf got %h exp %h", pc_f, 32'h0000_0040); else pass_cnt++;
      irq_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++; if (pc !== exp_pc[i]) $display("FAIL irq_pc%0d got %h exp %h", i, pc, exp_pc[i]); else pass_cnt++;
         total_cnt++; if (irqout !== exp_irq[i]) $display("FAIL irq_out%0d got %b exp %b", i, irqout, exp_irq[i]); else pass_cnt++;
         $display("txn irq %0d: pc_f=%h pc=%h irqout=%b", i, pc_f, pc, irqout);
      end
      pc_src = 3'd4;
      step();
      idle();
      total_cnt++; if (pc_f !== 32'h8000_0004) $display("FAIL irq_vec_pcf got %h exp %h", pc_f, 32'h8000_0004); else pass_cnt++;
      total_cnt++; if (irqout !== 1'b0) $display("FAIL irq_vec_bubble got %b exp 0", irqout); else pass_cnt++;
      irq_req = 1'b0;
      step();
      irq_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++; if (irqout !== 1'b0) $display("FAIL irq_masked%0d got %b exp 0", i, irqout); else pass_cnt++;
      end
      jump_reg(32'h0000_0060);
      step();
      total_cnt++; if (pc !== 32'h0000_0060) $display("FAIL irq_ret_pc got %h exp %h", pc, 32'h0000_0060); else pass_cnt++;
      total_cnt++; if (irqout !== 1'b1) $display("FAIL irq_unmasked got %b exp 1", irqout); else pass_cnt++;
      step();
      total_cnt++; if (irqout !== 1'b0) $display("FAIL irq_oneshot got %b exp 0", irqout); else pass_cnt++;
      $display("txn irq return: pc_f=%h pc=%h irqout=%b", pc_f, pc, irqout);
   endtask

   task automatic test_reset_override();
      stall  = 1'b1;
      pc_src = 3'd5;
      reset  = 1'b0;
      step();
      total_cnt++; if (pc_f !== 32'h8000_0000) $display("FAIL rst_ovr_pcf got %h exp %h", pc_f, 32'h8000_0000); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h0) $display("FAIL rst_ovr_instr got %h exp %h", instruct, 32'h0); else pass_cnt++;
      total_cnt++; if (pc !== 32'h0) $display("FAIL rst_ovr_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
      total_cnt++; if (irqout !== 1'b0) $display("FAIL rst_ovr_irqout got %b exp 0", irqout); else pass_cnt++;
      irq_req = 1'b0;
      idle();
      step();
      reset = 1'b1;
      step();
      total_cnt++; if (pc_f !== 32'h8000_0004) $display("FAIL rst_rel_pcf got %h exp %h", pc_f, 32'h8000_0004); else pass_cnt++;
      total_cnt++; if (instruct !== 32'h7FFF_FFFF) $display("FAIL rst_rel_instr got %h exp %h", instruct, 32'h7FFF_FFFF); else pass_cnt++;
      jump_reg(32'h0000_0010);
      step();
      total_cnt++; if (irqout !== 1'b0) $display("FAIL rst_pend_cleared got %b exp 0", irqout); else pass_cnt++;
      $display("txn reset override: pc_f=%h pc=%h irqout=%b", pc_f, pc, irqout);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_stall();
      test_branch_priority();
      test_exc_flush();
      test_wrap();
      test_irq();
      test_reset_override();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
